// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive buffer.
// Build option: UART_RX_FIFO_THR_IRQ_EN adds the fill-threshold IRQ.
package uart_pkg;

  localparam int RX_DATA_W   = 8;
  localparam int RX_ERR_W    = 2;
  localparam int RX_DEPTH    = 16;
  localparam int RX_RTS_HIGH = RX_DEPTH - 2;
  localparam int RX_RTS_LOW  = RX_DEPTH / 2;

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;

  localparam int RX_ENT_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: synchronous write, combinational read.
// Storage is deliberately not reset.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [RX_ENT_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [RX_ENT_W-1:0] rdata_o
);

  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= rx_entry_t'(wdata_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT FIFO with RTS hysteresis and overrun flag.
// Build option: UART_RX_FIFO_THR_IRQ_EN adds thr_level_i/thr_irq_o.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_W,
  parameter int DEPTH      = RX_DEPTH,
  parameter int RTS_HIGH   = DEPTH - 2,
  parameter int RTS_LOW    = DEPTH / 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    parity_err_i,
  input  logic                    frame_err_i,
  input  logic                    data_valid_i,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [1:0]              rd_err_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overrun_o,
  input  logic                    ovr_clr_i,
  output logic                    rts_no
`ifdef UART_RX_FIFO_THR_IRQ_EN
  ,
  input  logic [$clog2(DEPTH):0]  thr_level_i,
  output logic                    thr_irq_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          dv_q;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_d;
  logic          rts_q, rts_d;
  logic          ovr_q, ovr_d;
  rx_entry_t     hold_q, hold_d;
  rx_entry_t     head, wr_ent;
  logic          empty, full;
  logic          push_ev, push_ok, pop, ovr_set;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign push_ev = data_valid_i & ~dv_q;
  assign pop     = rd_en_i & ~empty;
  // A pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_ev & (~full | pop);
  assign ovr_set = push_ev & full & ~pop;

  assign wr_ent.frame_err  = frame_err_i;
  assign wr_ent.parity_err = parity_err_i;
  assign wr_ent.data       = data_i;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok & ~clr_i),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_ent),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q;
    rts_d    = rts_q;
    hold_d   = empty ? hold_q : head;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovr_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + CW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + CW'(1);
      if (ovr_set)        ovr_d = 1'b1;
      else if (ovr_clr_i) ovr_d = 1'b0;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    if (clr_i)                        rts_d = 1'b0;
    else if (count_d >= CW'(RTS_HIGH)) rts_d = 1'b1;
    else if (count_d <= CW'(RTS_LOW))  rts_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dv_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      rts_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      dv_q     <= data_valid_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      rts_q    <= rts_d;
      hold_q   <= hold_d;
    end
  end

`ifdef UART_RX_FIFO_THR_IRQ_EN
  logic thr_q, thr_d;

  always_comb begin
    thr_d = 1'b0;
    if (!clr_i && thr_level_i != '0) begin
      thr_d = (count_d >= thr_level_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) thr_q <= 1'b0;
    else          thr_q <= thr_d;
  end

  assign thr_irq_o = thr_q;
`endif

  // While empty, outputs hold the last head seen.
  assign rd_data_o = empty ? hold_q.data : head.data;
  assign rd_err_o  = empty ? {hold_q.frame_err, hold_q.parity_err}
                           : {head.frame_err, head.parity_err};
  assign empty_o   = empty;
  assign full_o    = full;
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign overrun_o = ovr_q;
  assign rts_no    = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Define UART_RX_FIFO_THR_IRQ_EN to also cover the threshold IRQ.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr_i;
  logic [7:0] data_i;
  logic       parity_err_i;
  logic       frame_err_i;
  logic       data_valid_i;
  logic       rd_en_i;
  logic [7:0] rd_data_o;
  logic [1:0] rd_err_o;
  logic       empty_o;
  logic       full_o;
  logic [4:0] count_o;
  logic       overrun_o;
  logic       ovr_clr_i;
  logic       rts_no;
`ifdef UART_RX_FIFO_THR_IRQ_EN
  logic [4:0] thr_level_i;
  logic       thr_irq_o;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] sb[$];
  logic exp_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr_i        (clr_i),
    .data_i       (data_i),
    .parity_err_i (parity_err_i),
    .frame_err_i  (frame_err_i),
    .data_valid_i (data_valid_i),
    .rd_en_i      (rd_en_i),
    .rd_data_o    (rd_data_o),
    .rd_err_o     (rd_err_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .overrun_o    (overrun_o),
    .ovr_clr_i    (ovr_clr_i),
    .rts_no       (rts_no)
`ifdef UART_RX_FIFO_THR_IRQ_EN
    ,
    .thr_level_i  (thr_level_i),
    .thr_irq_o    (thr_irq_o)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_lvl(input string tag);
    chk({tag, "_cnt"}, 32'(count_o), 32'(sb.size()));
    chk({tag, "_empty"}, 32'(empty_o), 32'(sb.size() == 0));
    chk({tag, "_full"}, 32'(full_o), 32'(sb.size() == DEPTH));
  endtask

  task automatic chk_head(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      chk(tag, 32'({rd_err_o, rd_data_o}), 32'(sb[0]));
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] e);
    @(negedge clk);
    data_i = d;
    {frame_err_i, parity_err_i} = e;
    data_valid_i = 1'b1;
    if (sb.size() < DEPTH) sb.push_back({e, d});
    else exp_ovr = 1'b1;
    @(negedge clk);
    data_valid_i = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    chk_head("pop_head");
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic push_pop(input logic [7:0] d);
    @(negedge clk);
    chk_head("pp_head");
    data_i = d;
    {frame_err_i, parity_err_i} = 2'b00;
    data_valid_i = 1'b1;
    rd_en_i = 1'b1;
    if (sb.size() != 0) void'(sb.pop_front());
    sb.push_back({2'b00, d});
    @(negedge clk);
    data_valid_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clr_i = 1'b0;
    data_i = '0;
    parity_err_i = 1'b0;
    frame_err_i = 1'b0;
    data_valid_i = 1'b0;
    rd_en_i = 1'b0;
    ovr_clr_i = 1'b0;
`ifdef UART_RX_FIFO_THR_IRQ_EN
    thr_level_i = 5'd0;
`endif
    repeat (3) @(negedge clk);
    chk_lvl("rst");
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_rts", 32'(rts_no), 32'd0);
    chk("rst_data", 32'({rd_err_o, rd_data_o}), 32'd0);
`ifdef UART_RX_FIFO_THR_IRQ_EN
    chk("rst_thr", 32'(thr_irq_o), 32'd0);
`endif
    reset_n = 1'b1;

    push(8'h41, 2'b00);
    push(8'h42, 2'b00);
    push(8'h43, 2'b00);
    chk_lvl("three");
    repeat (3) pop();
    chk_lvl("three_drain");

    // Level held five cycles: one push only.
    @(negedge clk);
    data_i = 8'h55;
    data_valid_i = 1'b1;
    sb.push_back({2'b00, 8'h55});
    repeat (5) @(negedge clk);
    data_valid_i = 1'b0;
    @(negedge clk);
    chk_lvl("held");
    pop();

    for (int i = 0; i < 14; i++) begin
      push(8'h60 + 8'(i), 2'b00);
      if (sb.size() == 13) chk("rts_13", 32'(rts_no), 32'd0);
    end
    chk_lvl("fill14");
    chk("rts_14", 32'(rts_no), 32'd1);
    while (sb.size() > 9) pop();
    chk("rts_9_down", 32'(rts_no), 32'd1);
    pop();
    chk("rts_8", 32'(rts_no), 32'd0);
    while (sb.size() < 13) push(8'h80 + 8'(sb.size()), 2'b00);
    chk("rts_13_up", 32'(rts_no), 32'd0);
    while (sb.size() < DEPTH) push(8'h90 + 8'(sb.size()), 2'b00);
    chk_lvl("fill16");
    chk("rts_16", 32'(rts_no), 32'd1);
    chk("ovr_pre", 32'(overrun_o), 32'd0);

    push(8'hAA, 2'b00);
    chk_lvl("drop");
    chk("ovr_set", 32'(overrun_o), 32'(exp_ovr));
    chk_head("drop_head");
    push_pop(8'hBB);
    chk_lvl("full_pp");
    chk("ovr_keep", 32'(overrun_o), 32'd1);
    @(negedge clk);
    ovr_clr_i = 1'b1;
    @(negedge clk);
    ovr_clr_i = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun_o), 32'd0);
    while (sb.size() > 0) pop();
    chk_lvl("drain16");
    chk("rts_0", 32'(rts_no), 32'd0);

    push(8'h10, 2'b01);
    push(8'h20, 2'b10);
    chk_head("err_par");
    pop();
    chk_head("err_frm");
    pop();
    @(negedge clk);
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
    chk_lvl("rd_empty");
    chk("rd_empty_hold", 32'({rd_err_o, rd_data_o}), 32'h220);
    chk("rd_empty_ovr", 32'(overrun_o), 32'd0);

`ifdef UART_RX_FIFO_THR_IRQ_EN
    thr_level_i = 5'd4;
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 2'b00);
    chk("thr_3", 32'(thr_irq_o), 32'd0);
    push(8'hC3, 2'b00);
    chk("thr_4", 32'(thr_irq_o), 32'd1);
    pop();
    chk("thr_back3", 32'(thr_irq_o), 32'd0);
    push(8'hC4, 2'b00);
    chk("thr_again", 32'(thr_irq_o), 32'd1);
`endif

    while (sb.size() < 10) push(8'hD0 + 8'(sb.size()), 2'b00);
    @(negedge clk);
    clr_i = 1'b1;
    data_valid_i = 1'b1;
    rd_en_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    data_valid_i = 1'b0;
    rd_en_i = 1'b0;
    sb.delete();
    chk_lvl("clr");
    chk("clr_rts", 32'(rts_no), 32'd0);
    chk("clr_ovr", 32'(overrun_o), 32'd0);
`ifdef UART_RX_FIFO_THR_IRQ_EN
    chk("clr_thr", 32'(thr_irq_o), 32'd0);
`endif

    push(8'hE1, 2'b00);
    push(8'hE2, 2'b00);
    push(8'hE3, 2'b00);
    chk_lvl("pre_rst");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk_lvl("mid_rst");
    chk("mid_rst_data", 32'({rd_err_o, rd_data_o}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(8'hF0, 2'b11);
    chk_head("post_rst");
    pop();
    chk_lvl("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
